prim_clock_gate_ctrl: RTL and testbench

//  Idle-driven enable generator for the clock-gating cell. Runs on the free-running clock.

---
 rtl/prim_clock_gate_ctrl_if.sv | 23 ++
 rtl/prim_clock_gate_ctrl.sv | 116 +++++++++++
 tb/tb_prim_clock_gate_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prim_clock_gate_ctrl_if.sv
// Control/status bundle between a clock-gate controller and its peripheral/software side.
interface prim_clock_gate_ctrl_if #(
    parameter int unsigned CntW = 16
);
    logic            gate_allow_i;
    logic            idle_i;
    logic            wake_req_i;
    logic            clr_cnt_i;
    logic            en_o;
    logic            gated_o;
    logic            wake_ack_o;
    logic [CntW-1:0] gate_event_cnt_o;

    modport master (
        output gate_allow_i, idle_i, wake_req_i, clr_cnt_i,
        input  en_o, gated_o, wake_ack_o, gate_event_cnt_o
    );

    modport slave (
        input  gate_allow_i, idle_i, wake_req_i, clr_cnt_i,
        output en_o, gated_o, wake_ack_o, gate_event_cnt_o
    );
endinterface

// File: rtl/prim_clock_gate_ctrl.sv
// Idle-driven enable generator for a clock-gate cell: idle hysteresis, wake handshake,
// gated status and a saturating count of gating events. All outputs come straight from flops.
module prim_clock_gate_ctrl #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntW       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    prim_clock_gate_ctrl_if.slave bus
);
    localparam int unsigned IdleW = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
    localparam int unsigned WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

    if (IdleCycles == 0 || WakeCycles == 0 || CntW == 0) begin : g_param_err
        $error("prim_clock_gate_ctrl: IdleCycles, WakeCycles and CntW must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [WakeW-1:0]  wake_cnt_q, wake_cnt_d;
    logic [CntW-1:0]   evt_cnt_q, evt_cnt_d;
    logic              en_q, en_d;
    logic              gated_q, gated_d;
    logic              ack_q, ack_d;
    logic              hold;

    assign hold = bus.gate_allow_i & bus.idle_i & ~bus.wake_req_i;

    // State and output registers; reset re-enables the clock immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            evt_cnt_q  <= '0;
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
            en_q       <= en_d;
            gated_q    <= gated_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        en_d       = en_q;
        gated_d    = gated_q;
        ack_d      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (hold) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = IdleW'(IdleCycles - 1);
                end
            end
            ST_COUNT: begin
                // A break in hold wins over an expiring count.
                if (!hold) begin
                    state_d = ST_RUN;
                end else if (idle_cnt_q == '0) begin
                    state_d   = ST_GATED;
                    en_d      = 1'b0;
                    gated_d   = 1'b1;
                    evt_cnt_d = (&evt_cnt_q) ? evt_cnt_q : evt_cnt_q + CntW'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q - IdleW'(1);
                end
            end
            ST_GATED: begin
                if (!hold) begin
                    state_d    = ST_WAKE;
                    en_d       = 1'b1;
                    gated_d    = 1'b0;
                    ack_d      = 1'b1;
                    wake_cnt_d = WakeW'(WakeCycles - 1);
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - WakeW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (bus.clr_cnt_i) begin
            evt_cnt_d = '0;
        end
    end

    assign bus.en_o             = en_q;
    assign bus.gated_o          = gated_q;
    assign bus.wake_ack_o       = ack_q;
    assign bus.gate_event_cnt_o = evt_cnt_q;
endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Scoreboard bench for prim_clock_gate_ctrl: directed per-cycle vectors queue their
// expected outputs; a monitor pops and compares after each clock edge or async reset.
module tb_prim_clock_gate_ctrl;
    localparam int unsigned IdleCycles = 4;
    localparam int unsigned WakeCycles = 2;
    localparam int unsigned CntW       = 2;

    typedef struct packed {
        logic            en;
        logic            gated;
        logic            ack;
        logic [CntW-1:0] cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    prim_clock_gate_ctrl_if #(.CntW(CntW)) bus ();

    prim_clock_gate_ctrl #(
        .IdleCycles(IdleCycles),
        .WakeCycles(WakeCycles),
        .CntW      (CntW)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.en_o !== e.en || bus.gated_o !== e.gated ||
                    bus.wake_ack_o !== e.ack || bus.gate_event_cnt_o !== e.cnt) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got en=%b gated=%b ack=%b cnt=%0d, want en=%b gated=%b ack=%b cnt=%0d",
                             $time, bus.en_o, bus.gated_o, bus.wake_ack_o, bus.gate_event_cnt_o,
                             e.en, e.gated, e.ack, e.cnt);
                end
            end
        end
    end

    // Drive n cycles of inputs (allow, idle, wake, clr); expect the given outputs after each edge.
    task automatic cyc(input int n, input logic a, input logic i, input logic w, input logic c,
                       input logic e_en, input logic e_g, input logic e_ack,
                       input logic [CntW-1:0] e_cnt);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            bus.gate_allow_i = a;
            bus.idle_i       = i;
            bus.wake_req_i   = w;
            bus.clr_cnt_i    = c;
            exp_q.push_back('{en: e_en, gated: e_g, ack: e_ack, cnt: e_cnt});
            @(posedge clk_i);
        end
    endtask

    initial begin
        bus.gate_allow_i = 1'b0;
        bus.idle_i       = 1'b0;
        bus.wake_req_i   = 1'b0;
        bus.clr_cnt_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Idle inputs after reset: clock stays on.
        cyc(100, 0, 0, 0, 0, 1, 0, 0, 2'd0);

        // Continuous hold: IdleCycles edges of counting, then gate.
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd0);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 2'd1);
        cyc(5, 1, 1, 0, 0, 0, 1, 0, 2'd1);

        // Wake pulse: ack + en on the same edge, WAKE ignores hold, then full recount.
        cyc(1, 1, 1, 1, 0, 1, 0, 1, 2'd1);
        cyc(2, 1, 1, 0, 0, 1, 0, 0, 2'd1);
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd1);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 2'd2);

        // gate_allow low forces a wake.
        cyc(1, 0, 1, 0, 0, 1, 0, 1, 2'd2);
        cyc(2, 0, 1, 0, 0, 1, 0, 0, 2'd2);

        // idle drops on the 3rd count cycle: hysteresis restarts from scratch.
        cyc(2, 1, 1, 0, 0, 1, 0, 0, 2'd2);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 2'd2);
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd2);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 2'd3);

        // Counter is at all-ones: another gating event must not wrap.
        cyc(1, 1, 1, 1, 0, 1, 0, 1, 2'd3);
        cyc(2, 1, 1, 0, 0, 1, 0, 0, 2'd3);
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd3);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 2'd3);

        // Hold breaks exactly when idle_cnt reaches 0: no gating, no count.
        cyc(1, 1, 1, 1, 0, 1, 0, 1, 2'd3);
        cyc(2, 1, 0, 0, 0, 1, 0, 0, 2'd3);
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd3);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 2'd3);

        // Clear on the gating edge wins over the increment.
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd3);
        cyc(1, 1, 1, 0, 1, 0, 1, 0, 2'd0);
        cyc(2, 1, 1, 0, 0, 0, 1, 0, 2'd0);

        // Async reset while gated: en returns before the next clock edge.
        @(negedge clk_i);
        #2;
        exp_q.push_back('{en: 1'b1, gated: 1'b0, ack: 1'b0, cnt: 2'd0});
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        bus.gate_allow_i = 1'b0;
        bus.idle_i       = 1'b0;
        rst_ni = 1'b1;

        // After reset the full hysteresis applies again and counting restarts at 1.
        cyc(3, 0, 0, 0, 0, 1, 0, 0, 2'd0);
        cyc(4, 1, 1, 0, 0, 1, 0, 0, 2'd0);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 2'd1);

        @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
